multiplexer2to1_round_robin_feeder: RTL and testbench
=====================================================

// Module: multiplexer2to1_round_robin_feeder
// PURPOSE
//  Upstream feeder stage for multiplexer2to1. Buffers two request channels in one-entry holding registers.
//  Arbitrates between them round-robin with per-packet burst lock.
//  Drives the registered selection and the paired held data for the mux, plus an output valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH     1  bits per channel beat (1 -> held_data maps directly onto mux input_signal[1:0])
//  BURST_LENGTH   4  max beats per grant before forced rotation; legal range 1..2**COUNTER_WIDTH
//  COUNTER_WIDTH  2  width of beat counter
// PORTS
//  clock         in   1             rising-edge clock, sole clock
//  reset         in   1             synchronous, active-high
//  input_valid   in   2             per-channel request valid, bit i = channel i
//  input_ready   out  2             per-channel accept; transfer when valid&ready
//  input_data    in   2*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  input_last    in   2             end-of-packet marker per channel
//  held_data     out  2*DATA_WIDTH  holding-register contents, to mux input_signal
//  selection     out  1             granted channel, registered, to mux selection
//  output_valid  out  1             granted channel's holding register is full
//  output_ready  in   1             downstream accepts the beat
//  output_last   out  1             held last flag of granted channel
//  busy          out  1             state != IDLE
// BEHAVIOUR
//  Reset values:
//   - full[1:0]=0; held_data=0; held last=0; state=IDLE; selection=0.
//   - last_grant=1, so channel 0 wins first; beat_count=0; output_valid=0; output_last=0; busy=0.
//  Reset mid-operation discards held beats; no beat emerges after reset.
//  pop = output_valid & output_ready.
//  Holding register i:
//   - input_ready[i] = ~full[i] | (pop & selection==i). This combinational path from output_ready is allowed.
//   - Push loads data and last, and sets full.
//   - Pop without push clears full.
//   - Push and pop in the same cycle reloads the register; full stays 1.
//  FSM states: IDLE, GRANT0, GRANT1. selection is updated only on entry to a GRANT state.
//   - IDLE: output_valid=0.
//     - If both full: go to GRANT(~last_grant).
//     - Else if one full: go to that channel's GRANT.
//     - Set beat_count=0.
//   - GRANTk: output_valid=full[k].
//     - On pop: beat_count+1.
//     - Release when pop & (held last[k] | beat_count==BURST_LENGTH-1). On release: last_grant<=k, beat_count<=0.
//     - After release: go to GRANT(~k) if full[~k] in that cycle, else IDLE.
//     - Without pop: stay in GRANTk (packet lock), even if full[k]=0.
//  Latency:
//   - Push in IDLE at cycle N: full at N+1, GRANT entered at N+2, output_valid=1 at N+2.
//   - Push into an empty register under an active grant: output_valid at N+1.
//   - Back-to-back: 1 beat/cycle while the granted channel keeps its register refilled.
//  BURST_LENGTH=1 rotates after every beat.
//  The counter never wraps: release occurs at BURST_LENGTH-1.
//  held_data is driven at all times; its contents are meaningless where full=0.
//  output_last=0 when output_valid=0.
// STRUCTURE
//  Shared include multiplexer2to1_definitions.vh (include-guarded):
//   - state encodings IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2
//   - CHANNEL_COUNT=2
//  Sub-module input_holding_register:
//   - one-entry data+last register with full flag and ready logic
//   - instantiated twice
//  The FSM, beat counter and round-robin pointer stay in the top module.
// TESTING
//  1. Reset held 2 cycles, then released.
//     Required: output_valid=0, input_ready=2'b11, selection=0, busy=0, held_data=0.
//  2. Single beat on ch1, data=1, last=1, at cycle 5.
//     Required: GRANT1 at cycle 7; selection=1; output_valid=1; output_last=1.
//     Then, with output_ready=1, state returns to IDLE at cycle 8.
//  3. Both channels request continuously, last=0, BURST_LENGTH=4, output_ready=1.
//     Required: beats alternate in groups of 4: ch0 x4, ch1 x4, ch0 x4.
//     No idle cycle between groups.
//  4. ch0 sends a 2-beat packet (last on beat 2) while ch1 is pending.
//     Required: the grant moves to ch1 right after beat 2; the burst counter is reset.
//  5. Backpressure: output_ready=0 for 5 cycles with ch0 full.
//     Required: output_valid stays 1; held_data stable; input_ready[0]=0.
//     After output_ready rises: exactly one pop; input_ready[0]=1 in the same cycle.
//  6. Reset asserted mid-burst (beat 2 of 4).
//     Required: next cycle state=IDLE, full=0, output_valid=0; no stale beat emitted afterwards.

Source files
------------

// File: rtl/multiplexer2to1_round_robin_feeder_pkg.sv
// multiplexer2to1_round_robin_feeder_pkg: shared FSM encodings and channel count for the feeder
package multiplexer2to1_round_robin_feeder_pkg;
  localparam int CHANNEL_COUNT = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;
  function automatic state_t grant_state(input logic ch);
    return ch ? GRANT1 : GRANT0;
  endfunction
endpackage

// File: rtl/multiplexer2to1_round_robin_feeder_input_holding_register.sv
// multiplexer2to1_round_robin_feeder_input_holding_register: one-entry data+last buffer with full flag
module multiplexer2to1_round_robin_feeder_input_holding_register #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  last,
  input  logic                  pop,
  output logic                  ready,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] held_data,
  output logic                  held_last
);
  logic push;
  assign ready = ~full | pop;
  assign push = valid & ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 1'b0;
      held_data <= '0;
      held_last <= 1'b0;
    end else begin
      if (push) begin
        held_data <= data;
        held_last <= last;
      end
      full <= push | (full & ~pop);
    end
  end
endmodule

// File: rtl/multiplexer2to1_round_robin_feeder.sv
// multiplexer2to1_round_robin_feeder: buffers two channels and grants them round-robin with burst lock
module multiplexer2to1_round_robin_feeder
  import multiplexer2to1_round_robin_feeder_pkg::*;
#(
  parameter int DATA_WIDTH    = 1,
  parameter int BURST_LENGTH  = 4,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              input_valid,
  output logic [1:0]              input_ready,
  input  logic [2*DATA_WIDTH-1:0] input_data,
  input  logic [1:0]              input_last,
  output logic [2*DATA_WIDTH-1:0] held_data,
  output logic                    selection,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic                    output_last,
  output logic                    busy
);
  state_t state, state_next;
  logic last_grant;
  logic [COUNTER_WIDTH-1:0] beat_count;
  logic [CHANNEL_COUNT-1:0] full, held_last;
  logic granted, pop, release_grant;
  assign granted = state == GRANT1;
  assign pop = output_valid & output_ready;
  assign release_grant = pop & (held_last[granted] | beat_count == COUNTER_WIDTH'(BURST_LENGTH - 1));
  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_hold
    multiplexer2to1_round_robin_feeder_input_holding_register #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
      .clock     (clock),
      .reset     (reset),
      .valid     (input_valid[i]),
      .data      (input_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .last      (input_last[i]),
      .pop       (pop & (selection == 1'(i))),
      .ready     (input_ready[i]),
      .full      (full[i]),
      .held_data (held_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .held_last (held_last[i])
    );
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      selection <= 1'b0;
      last_grant <= 1'b1;
      beat_count <= '0;
    end else begin
      state <= state_next;
      if (state_next != IDLE && state_next != state) selection <= state_next == GRANT1;
      if (release_grant) last_grant <= granted;
      beat_count <= (state == IDLE || release_grant) ? '0 : beat_count + COUNTER_WIDTH'(pop);
    end
  end
  // Without a release the grant holds even with an empty register: packet lock
  always_comb begin
    state_next = state;
    if (state == IDLE)
      state_next = &full ? grant_state(~last_grant) : full[0] ? GRANT0 : full[1] ? GRANT1 : IDLE;
    else if (release_grant)
      state_next = full[~granted] ? grant_state(~granted) : IDLE;
  end
  always_comb begin
    output_valid = (state != IDLE) & full[granted];
    output_last = output_valid & held_last[granted];
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_multiplexer2to1_round_robin_feeder.sv
// tb_multiplexer2to1_round_robin_feeder: directed and random checks against a channel/burst reference model
module tb_multiplexer2to1_round_robin_feeder;
  localparam int BL = 4;
  logic clock = 1'b0, reset;
  logic [1:0] input_valid, input_ready, input_data, input_last, held_data;
  logic selection, output_valid, output_ready, output_last, busy;
  int checks = 0, errors = 0;
  int owner, sel, rr, beats;
  bit mfull[2], mdata[2], mlast[2];
  bit autoclr;
  int popped[$];

  multiplexer2to1_round_robin_feeder #(.DATA_WIDTH(1), .BURST_LENGTH(BL), .COUNTER_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .input_last(input_last), .held_data(held_data), .selection(selection),
    .output_valid(output_valid), .output_ready(output_ready), .output_last(output_last), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; sel = 0; rr = 0; beats = 0;
    for (int i = 0; i < 2; i++) begin mfull[i] = 0; mdata[i] = 0; mlast[i] = 0; end
  endtask

  // owner = channel currently holding the grant (-1 when idle); rr = channel preferred on a tie
  task automatic cycle(input bit check);
    bit ov, pop, rst;
    bit [1:0] rdy, iv, idt, il;
    int nxt;
    #1;
    ov = owner >= 0 && mfull[owner];
    pop = ov && output_ready;
    for (int i = 0; i < 2; i++) rdy[i] = !mfull[i] || (pop && owner == i);
    if (check && !reset) begin
      chk("output_valid", output_valid, ov);
      chk("input_ready", input_ready, rdy);
      chk("selection", selection, sel);
      chk("output_last", output_last, ov ? mlast[owner] : 1'b0);
      chk("busy", busy, owner >= 0);
      chk("held_data", held_data, {mdata[1], mdata[0]});
    end
    if (pop && !reset) popped.push_back(owner);
    iv = input_valid; idt = input_data; il = input_last; rst = reset;
    @(posedge clock);
    @(negedge clock);
    if (rst) model_reset();
    else begin
      nxt = owner;
      if (owner < 0) begin
        beats = 0;
        nxt = (mfull[0] && mfull[1]) ? rr : mfull[0] ? 0 : mfull[1] ? 1 : -1;
      end else if (pop) begin
        beats++;
        if (mlast[owner] || beats == BL) begin
          rr = 1 - owner;
          beats = 0;
          nxt = mfull[1 - owner] ? 1 - owner : -1;
        end
      end
      for (int i = 0; i < 2; i++)
        if (iv[i] && rdy[i]) begin mfull[i] = 1; mdata[i] = idt[i]; mlast[i] = il[i]; end
        else if (pop && owner == i) mfull[i] = 0;
      if (nxt >= 0 && nxt != owner) sel = nxt;
      owner = nxt;
      if (autoclr) input_valid = input_valid & ~rdy;
    end
  endtask

  task automatic do_reset();
    reset = 1; input_valid = 0; input_data = 0; input_last = 0; output_ready = 0;
    cycle(0); cycle(0);
    reset = 0;
    popped.delete();
  endtask

  initial begin
    model_reset();
    autoclr = 1;
    @(negedge clock);
    // reset values
    do_reset();
    #1;
    chk("rst_output_valid", output_valid, 0);
    chk("rst_input_ready", input_ready, 2'b11);
    chk("rst_selection", selection, 0);
    chk("rst_busy", busy, 0);
    chk("rst_held_data", held_data, 0);
    cycle(1);
    // single last beat on ch1: grant two cycles after push, back to idle after pop
    output_ready = 1;
    input_valid = 2'b10; input_data = 2'b10; input_last = 2'b10;
    cycle(1); cycle(1);
    chk("t2_busy", busy, 1);
    chk("t2_selection", selection, 1);
    chk("t2_output_valid", output_valid, 1);
    chk("t2_output_last", output_last, 1);
    cycle(1);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_valid", output_valid, 0);
    // continuous requests on both channels rotate in bursts of BL
    popped.delete();
    autoclr = 0; input_last = 0;
    for (int c = 0; c < 16; c++) begin
      input_valid = 2'b11; input_data = 2'($urandom);
      cycle(1);
    end
    chk("t3_pop_count", popped.size(), 14);
    for (int i = 0; i < 12; i++) chk("t3_burst_order", popped[i], (i / BL) % 2);
    // two-beat packet on ch0 with ch1 pending
    do_reset();
    autoclr = 1; output_ready = 1;
    input_valid = 2'b11; input_data = 2'b01; input_last = 2'b10;
    cycle(1);
    input_valid = 2'b01; input_data = 2'b00; input_last = 2'b01;
    for (int c = 0; c < 6; c++) cycle(1);
    chk("t4_pop_count", popped.size(), 3);
    chk("t4_order", {popped[0][1:0], popped[1][1:0], popped[2][1:0]}, 6'b00_00_01);
    // backpressure on a granted ch0
    do_reset();
    autoclr = 1; output_ready = 0;
    input_valid = 2'b01; input_data = 2'b01; input_last = 2'b00;
    cycle(1); cycle(1);
    input_valid = 2'b01; input_data = 2'b00;
    for (int c = 0; c < 5; c++) begin
      chk("t5_valid_held", output_valid, 1);
      chk("t5_data_stable", held_data[0], 1);
      chk("t5_ready_low", input_ready[0], 0);
      cycle(1);
    end
    output_ready = 1;
    #1;
    chk("t5_ready_on_pop", input_ready[0], 1);
    cycle(1);
    output_ready = 0;
    cycle(1); cycle(1);
    chk("t5_single_pop", popped.size(), 1);
    // reset in the middle of a burst
    do_reset();
    autoclr = 0; output_ready = 1;
    input_valid = 2'b01; input_data = 2'b01; input_last = 2'b00;
    for (int c = 0; c < 4; c++) cycle(1);
    chk("t6_pops_before", popped.size(), 2);
    reset = 1;
    cycle(0);
    reset = 0; input_valid = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_output_valid", output_valid, 0);
    chk("t6_empty", input_ready, 2'b11);
    for (int c = 0; c < 6; c++) cycle(1);
    chk("t6_no_stale", popped.size(), 2);
    // random traffic with occasional resets
    autoclr = 0;
    for (int c = 0; c < 400; c++) begin
      input_valid = 2'($urandom); input_data = 2'($urandom); input_last = 2'($urandom);
      output_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 99) == 0;
      cycle(1);
    end
    reset = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
